arbitro_posicionamento: RTL and testbench
=========================================

# arbitro_posicionamento

Sequencer and arbiter for the piece-placement phase of the naval battle game. Two requesters, the CPU random-placement interface (jogador=0) and the human placement interface (jogador=1), share the single conflict validator and board memory. The block grants the validator to one requester at a time, enforces the fleet quota per player, and raises `start_game` once both fleets are complete.

## Interface
Parameters:
- `BOARD`, 10: board side; coordinates 0..BOARD-1 are legal.
- `VAL_TIMEOUT`, 15: maximum cycles to wait for `val_done` before aborting.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_cpu`, `req_hum`  in  1 each  placement request; held high with its fields stable until the matching ack.
- `tipo_cpu`, `tipo_hum`  in  3 each  piece type (0 submarino, 1 cruzador, 2 hidroaviao, 3 encouracado, 4 porta-avioes).
- `x_cpu`, `y_cpu`, `x_hum`, `y_hum`  in  4 each  anchor coordinates.
- `dir_cpu`, `dir_hum`  in  1 each  direction.
- `ori_cpu`, `ori_hum`  in  3 each  orientation.
- `ack_cpu`, `ack_hum`  out  1 each  one-cycle completion pulse.
- `gnt_cpu`, `gnt_hum`  out  1 each  high while that requester owns the validator.
- `resp_conflito`  out  1  valid with ack: placement rejected by the validator or timed out.
- `resp_erro`  out  1  valid with ack: request rejected locally (bad type, bad coordinate, quota exhausted, or timeout).
- `val_start`  out  1  one-cycle pulse that starts the validator.
- `val_tipo`  out  3, `val_x`, `val_y`  out  4 each, `val_direcao`  out  1, `val_orientacao`  out  3, `val_jogador`  out  1  latched request fields; stable from `val_start` until ack.
- `val_done`  in  1  validator finished.
- `val_conflito`  in  1  validator result; valid when `val_done` is high.
- `fleet_done_cpu`, `fleet_done_hum`  out  1 each  that player has placed all 11 pieces.
- `start_game`  out  1  level; equals `fleet_done_cpu & fleet_done_hum`.

## Operation
- All outputs are registered. Under reset every output is 0, all counters are 0, the state is IDLE, and the priority pointer favours the CPU.
- Quota per player: 5 submarino, 2 cruzador, 2 hidroaviao, 1 encouracado, 1 porta-avioes, 11 pieces total. Each count is 3 bits per type per player.
- State IDLE:
  - With no req, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, the pointer decides. The pointer flips to the other requester after every ack, which gives round-robin.
  - The winner's fields are latched. If tipo>4, x≥BOARD, y≥BOARD, or that type's quota is already full, go to REJECT. Otherwise go to ISSUE.
- State REJECT: pulse ack with `resp_erro`=1 and `resp_conflito`=0; the validator is not touched; go to IDLE.
- State ISSUE: `val_start`=1 and gnt=1; go to WAIT and clear the timeout counter.
- State WAIT: gnt stays high and the counter increments.
  - On `val_done`, capture `val_conflito` and go to RESP.
  - If the counter reaches VAL_TIMEOUT, go to RESP with conflito=1 and erro=1.
- State RESP:
  - Pulse ack and drop gnt.
  - On conflito=0 and erro=0, increment that player/type count.
  - Then go to IDLE.
- A `val_done` seen outside WAIT is ignored.
- A req dropped mid-transaction does not abort it; the ack is still pulsed.
- `fleet_done_x` updates in the cycle after the 11th successful count.

## Timing
- Accepted request sampled in IDLE at cycle 0: `val_start` and gnt are high at cycle 1.
- `val_done` sampled high at cycle k (k≥2): ack is high at cycle k+1, and IDLE samples req again at k+2.
- The requester must deassert req at cycle k+2, or it is taken as a new request.
- Rejected request sampled at cycle 0: ack with erro at cycle 1.
- Timeout: ack at cycle 2+VAL_TIMEOUT when `val_done` never rises.
- Reset asserted at any cycle: the next cycle is IDLE with all outputs 0. An in-flight transaction is dropped without an ack.

## Structure
- Package `batalha_pkg` holds:
  - piece-type constants 0..4;
  - quota constants 5, 2, 2, 1, 1;
  - the FLEET_SIZE=11 constant;
  - the state enumeration IDLE/REJECT/ISSUE/WAIT/RESP.
- One sub-module, `contador_frota`, instantiated once per player. It holds the per-type counters and exposes `quota_cheia[tipo]`, `incr`, and `fleet_done`.

## Test plan
- CPU only, tipo=0 at (3,4), validator returns done with conflito=0 two cycles after start → `val_start` at cycle 1 with `val_x`=3 and `val_y`=4; `ack_cpu` at cycle 4 with conflito=0 and erro=0; submarino count becomes 1.
- Both req high simultaneously after reset → CPU granted first, then the human after the CPU's ack. With both held high continuously, grants strictly alternate.
- Human places 5 submarinos successfully, then a 6th tipo=0 → ack at cycle 1 with erro=1 and no `val_start`.
- `tipo_cpu`=5, or `x_cpu`=10 → immediate ack with erro=1.
- Validator never raises `val_done` → ack at cycle 17 with conflito=1 and erro=1; the count is unchanged.
- Both players complete 11 valid placements → `fleet_done_cpu` and `fleet_done_hum` are set and `start_game`=1. Reset asserted mid-WAIT → all counters cleared and `start_game`=0 on the next cycle.

Source files
------------

// File: rtl/arbitro_posicionamento_pkg.sv
// Shared types and constants for the placement-phase arbiter of the naval battle game.
// Piece types, per-type fleet quotas and the arbiter state encoding live here.
package batalha_pkg;

  localparam logic [2:0] TIPO_SUBMARINO    = 3'd0;
  localparam logic [2:0] TIPO_CRUZADOR     = 3'd1;
  localparam logic [2:0] TIPO_HIDROAVIAO   = 3'd2;
  localparam logic [2:0] TIPO_ENCOURACADO  = 3'd3;
  localparam logic [2:0] TIPO_PORTA_AVIOES = 3'd4;

  localparam logic [2:0] QUOTA_SUBMARINO    = 3'd5;
  localparam logic [2:0] QUOTA_CRUZADOR     = 3'd2;
  localparam logic [2:0] QUOTA_HIDROAVIAO   = 3'd2;
  localparam logic [2:0] QUOTA_ENCOURACADO  = 3'd1;
  localparam logic [2:0] QUOTA_PORTA_AVIOES = 3'd1;

  localparam int NUM_TIPOS  = 5;
  localparam int FLEET_SIZE = 11;

  typedef enum logic [2:0] {
    IDLE,
    REJECT,
    ISSUE,
    WAIT,
    RESP
  } estado_t;

  typedef struct packed {
    logic [2:0] tipo;
    logic [3:0] x;
    logic [3:0] y;
    logic       direcao;
    logic [2:0] orientacao;
  } pedido_t;

  function automatic logic [2:0] quota_tipo(input logic [2:0] tipo);
    case (tipo)
      TIPO_SUBMARINO:    quota_tipo = QUOTA_SUBMARINO;
      TIPO_CRUZADOR:     quota_tipo = QUOTA_CRUZADOR;
      TIPO_HIDROAVIAO:   quota_tipo = QUOTA_HIDROAVIAO;
      TIPO_ENCOURACADO:  quota_tipo = QUOTA_ENCOURACADO;
      TIPO_PORTA_AVIOES: quota_tipo = QUOTA_PORTA_AVIOES;
      default:           quota_tipo = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/arbitro_posicionamento_if.sv
// Bus between the placement arbiter (master) and the shared conflict validator (slave).
interface arbitro_posicionamento_if;
  logic       val_start;
  logic [2:0] val_tipo;
  logic [3:0] val_x;
  logic [3:0] val_y;
  logic       val_direcao;
  logic [2:0] val_orientacao;
  logic       val_jogador;
  logic       val_done;
  logic       val_conflito;

  modport master (
    output val_start, val_tipo, val_x, val_y, val_direcao, val_orientacao, val_jogador,
    input  val_done, val_conflito
  );

  modport slave (
    input  val_start, val_tipo, val_x, val_y, val_direcao, val_orientacao, val_jogador,
    output val_done, val_conflito
  );
endinterface

// File: rtl/arbitro_posicionamento_contador_frota.sv
// Per-player fleet counter: one 3-bit count per piece type, quota-full flags and fleet completion.
module contador_frota
  import batalha_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       incr,
  input  logic [2:0] tipo,
  output logic [7:0] quota_cheia,
  output logic       fleet_done,
  output logic       fleet_done_nxt
);

  logic [NUM_TIPOS-1:0][2:0] cnt;
  logic [NUM_TIPOS-1:0][2:0] cnt_nxt;
  logic [3:0]                total_nxt;

  // Unused type codes 5..7 read as permanently full.
  always_comb begin
    cnt_nxt     = cnt;
    quota_cheia = '1;
    total_nxt   = '0;
    for (int t = 0; t < NUM_TIPOS; t++) begin
      quota_cheia[t] = (cnt[t] >= quota_tipo(3'(t)));
      if (incr && (tipo == 3'(t)) && (cnt[t] < quota_tipo(3'(t))))
        cnt_nxt[t] = cnt[t] + 3'd1;
      total_nxt = total_nxt + {1'b0, cnt_nxt[t]};
    end
    fleet_done_nxt = (total_nxt == 4'(FLEET_SIZE));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      fleet_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      fleet_done <= fleet_done_nxt;
    end
  end

endmodule

// File: rtl/arbitro_posicionamento.sv
// Round-robin arbiter granting the shared conflict validator to the CPU or human placement
// requester, with local legality/quota rejection, validator timeout and fleet completion.
module arbitro_posicionamento
  import batalha_pkg::*;
#(
  parameter int BOARD       = 10,
  parameter int VAL_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_cpu,
  input  logic       req_hum,
  input  logic [2:0] tipo_cpu,
  input  logic [2:0] tipo_hum,
  input  logic [3:0] x_cpu,
  input  logic [3:0] y_cpu,
  input  logic [3:0] x_hum,
  input  logic [3:0] y_hum,
  input  logic       dir_cpu,
  input  logic       dir_hum,
  input  logic [2:0] ori_cpu,
  input  logic [2:0] ori_hum,
  output logic       ack_cpu,
  output logic       ack_hum,
  output logic       gnt_cpu,
  output logic       gnt_hum,
  output logic       resp_conflito,
  output logic       resp_erro,
  arbitro_posicionamento_if.master val,
  output logic       fleet_done_cpu,
  output logic       fleet_done_hum,
  output logic       start_game
);

  localparam int         TW      = $clog2(VAL_TIMEOUT + 1);
  localparam logic [4:0] BOARD_L = 5'(BOARD);

  estado_t    state;
  logic       ptr;
  logic [TW-1:0] cnt_to;

  logic       sel_hum;
  pedido_t    sel;
  logic       cheia;
  logic       invalido;
  logic [7:0] cheia_cpu;
  logic [7:0] cheia_hum;
  logic       fd_nxt_cpu;
  logic       fd_nxt_hum;
  logic       incr_cpu;
  logic       incr_hum;

  // ptr=0 favours the CPU when both requesters are waiting.
  always_comb begin
    sel_hum  = req_hum && (!req_cpu || ptr);
    sel      = sel_hum ? '{tipo_hum, x_hum, y_hum, dir_hum, ori_hum}
                       : '{tipo_cpu, x_cpu, y_cpu, dir_cpu, ori_cpu};
    cheia    = sel_hum ? cheia_hum[sel.tipo] : cheia_cpu[sel.tipo];
    invalido = (sel.tipo > TIPO_PORTA_AVIOES) ||
               ({1'b0, sel.x} >= BOARD_L) ||
               ({1'b0, sel.y} >= BOARD_L) ||
               cheia;
    incr_cpu = (state == RESP) && !val.val_jogador && !resp_conflito && !resp_erro;
    incr_hum = (state == RESP) &&  val.val_jogador && !resp_conflito && !resp_erro;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      ptr                <= 1'b0;
      cnt_to             <= '0;
      ack_cpu            <= 1'b0;
      ack_hum            <= 1'b0;
      gnt_cpu            <= 1'b0;
      gnt_hum            <= 1'b0;
      resp_conflito      <= 1'b0;
      resp_erro          <= 1'b0;
      start_game         <= 1'b0;
      val.val_start      <= 1'b0;
      val.val_tipo       <= '0;
      val.val_x          <= '0;
      val.val_y          <= '0;
      val.val_direcao    <= 1'b0;
      val.val_orientacao <= '0;
      val.val_jogador    <= 1'b0;
    end else begin
      val.val_start <= 1'b0;
      ack_cpu       <= 1'b0;
      ack_hum       <= 1'b0;
      start_game    <= fd_nxt_cpu & fd_nxt_hum;
      case (state)
        IDLE: begin
          if (req_cpu || req_hum) begin
            val.val_tipo       <= sel.tipo;
            val.val_x          <= sel.x;
            val.val_y          <= sel.y;
            val.val_direcao    <= sel.direcao;
            val.val_orientacao <= sel.orientacao;
            val.val_jogador    <= sel_hum;
            if (invalido) begin
              state         <= REJECT;
              ack_cpu       <= !sel_hum;
              ack_hum       <= sel_hum;
              resp_erro     <= 1'b1;
              resp_conflito <= 1'b0;
              ptr           <= !sel_hum;
            end else begin
              state         <= ISSUE;
              val.val_start <= 1'b1;
              gnt_cpu       <= !sel_hum;
              gnt_hum       <= sel_hum;
            end
          end
        end
        REJECT: begin
          resp_erro     <= 1'b0;
          resp_conflito <= 1'b0;
          state         <= IDLE;
        end
        ISSUE: begin
          cnt_to <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (val.val_done || (cnt_to == TW'(VAL_TIMEOUT - 1))) begin
            resp_conflito <= val.val_done ? val.val_conflito : 1'b1;
            resp_erro     <= !val.val_done;
            ack_cpu       <= !val.val_jogador;
            ack_hum       <= val.val_jogador;
            gnt_cpu       <= 1'b0;
            gnt_hum       <= 1'b0;
            ptr           <= !val.val_jogador;
            state         <= RESP;
          end else begin
            cnt_to <= cnt_to + 1'b1;
          end
        end
        RESP: begin
          resp_erro     <= 1'b0;
          resp_conflito <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  contador_frota u_frota_cpu (
    .clk            (clk),
    .reset          (reset),
    .incr           (incr_cpu),
    .tipo           (val.val_tipo),
    .quota_cheia    (cheia_cpu),
    .fleet_done     (fleet_done_cpu),
    .fleet_done_nxt (fd_nxt_cpu)
  );

  contador_frota u_frota_hum (
    .clk            (clk),
    .reset          (reset),
    .incr           (incr_hum),
    .tipo           (val.val_tipo),
    .quota_cheia    (cheia_hum),
    .fleet_done     (fleet_done_hum),
    .fleet_done_nxt (fd_nxt_hum)
  );

endmodule

// File: tb/tb_arbitro_posicionamento.sv
// Directed bench for arbitro_posicionamento: vector table of single placements plus
// sequences for quota exhaustion, reset in WAIT, round-robin and fleet completion.
module tb_arbitro_posicionamento;
  import batalha_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_cpu = 0, req_hum = 0;
  logic [2:0] tipo_cpu = 0, tipo_hum = 0, ori_cpu = 0, ori_hum = 0;
  logic [3:0] x_cpu = 0, y_cpu = 0, x_hum = 0, y_hum = 0;
  logic       dir_cpu = 0, dir_hum = 0;
  logic       ack_cpu, ack_hum, gnt_cpu, gnt_hum, resp_conflito, resp_erro;
  logic       fleet_done_cpu, fleet_done_hum, start_game;

  arbitro_posicionamento_if vif();

  arbitro_posicionamento #(.BOARD(10), .VAL_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_cpu(req_cpu), .req_hum(req_hum),
    .tipo_cpu(tipo_cpu), .tipo_hum(tipo_hum),
    .x_cpu(x_cpu), .y_cpu(y_cpu), .x_hum(x_hum), .y_hum(y_hum),
    .dir_cpu(dir_cpu), .dir_hum(dir_hum), .ori_cpu(ori_cpu), .ori_hum(ori_hum),
    .ack_cpu(ack_cpu), .ack_hum(ack_hum), .gnt_cpu(gnt_cpu), .gnt_hum(gnt_hum),
    .resp_conflito(resp_conflito), .resp_erro(resp_erro),
    .val(vif),
    .fleet_done_cpu(fleet_done_cpu), .fleet_done_hum(fleet_done_hum),
    .start_game(start_game)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_cpu = 0; req_hum = 0;
    vif.val_done = 0; vif.val_conflito = 0;
    step(); step();
    reset = 1'b1;
  endtask

  // Issue one request; the bench validator answers 'delay' cycles after val_start (never if <=0).
  task automatic transacao(input string nm, input logic jog, input logic [2:0] tipo,
                           input logic [3:0] x, input logic [3:0] y, input int delay,
                           input logic conf, output int c_start, output int c_ack,
                           output logic r_conf, output logic r_erro);
    int cyc;
    cyc = 0; c_start = -1; c_ack = -1; r_conf = 0; r_erro = 0;
    if (jog) begin tipo_hum = tipo; x_hum = x; y_hum = y; req_hum = 1; end
    else     begin tipo_cpu = tipo; x_cpu = x; y_cpu = y; req_cpu = 1; end
    while (c_ack < 0 && cyc < 40) begin
      step();
      cyc++;
      if (vif.val_start && c_start < 0) begin
        c_start = cyc;
        chk({nm, " val_x"}, int'(vif.val_x), int'(x));
        chk({nm, " val_y"}, int'(vif.val_y), int'(y));
        chk({nm, " gnt"}, int'(jog ? gnt_hum : gnt_cpu), 1);
      end
      if (jog ? ack_hum : ack_cpu) begin
        c_ack  = cyc;
        r_conf = resp_conflito;
        r_erro = resp_erro;
        req_cpu = 0; req_hum = 0;
      end
      vif.val_done     = (c_start >= 0) && (delay > 0) && (cyc == c_start + delay);
      vif.val_conflito = vif.val_done ? conf : 1'b0;
    end
    vif.val_done = 0; vif.val_conflito = 0;
    req_cpu = 0; req_hum = 0;
    step();
  endtask

  typedef struct {
    logic       jog;
    logic [2:0] tipo;
    logic [3:0] x;
    logic [3:0] y;
    int         delay;
    logic       conf;
    int         e_start;
    int         e_ack;
    logic       e_conf;
    logic       e_erro;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cs, ca;
    logic rc, re;
    logic [2:0] frota [11];
    int acks [$];
    int gnts [$];

    vecs[0] = '{1'b0, 3'd0, 4'd3, 4'd4,  2, 1'b0,  1,  4, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 3'd5, 4'd1, 4'd1,  2, 1'b0, -1,  1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 3'd1, 4'd10, 4'd1, 2, 1'b0, -1,  1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 3'd1, 4'd2, 4'd12, 2, 1'b0, -1,  1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 3'd1, 4'd0, 4'd9,  3, 1'b1,  1,  5, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 3'd2, 4'd5, 4'd5, -1, 1'b0,  1, 17, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 3'd4, 4'd9, 4'd9,  1, 1'b0,  1,  3, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 3'd4, 4'd0, 4'd0,  1, 1'b0, -1,  1, 1'b0, 1'b1};
    frota = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};

    do_reset();
    chk("reset outputs",
        int'({ack_cpu, ack_hum, gnt_cpu, gnt_hum, resp_conflito, resp_erro, vif.val_start,
              vif.val_x, vif.val_y, fleet_done_cpu, fleet_done_hum, start_game}), 0);

    for (int i = 0; i < 8; i++) begin
      transacao($sformatf("vec%0d", i), vecs[i].jog, vecs[i].tipo, vecs[i].x, vecs[i].y,
                vecs[i].delay, vecs[i].conf, cs, ca, rc, re);
      chk($sformatf("vec%0d start_cycle", i), cs, vecs[i].e_start);
      chk($sformatf("vec%0d ack_cycle", i), ca, vecs[i].e_ack);
      chk($sformatf("vec%0d conflito", i), int'(rc), int'(vecs[i].e_conf));
      chk($sformatf("vec%0d erro", i), int'(re), int'(vecs[i].e_erro));
    end

    chk("cpu submarino count", int'(dut.u_frota_cpu.cnt[0]), 1);
    chk("cpu cruzador count after conflict", int'(dut.u_frota_cpu.cnt[1]), 0);
    chk("cpu hidroaviao count after timeout", int'(dut.u_frota_cpu.cnt[2]), 0);
    chk("hum porta-avioes count", int'(dut.u_frota_hum.cnt[4]), 1);

    // Human fills its submarino quota, then a sixth is refused locally.
    for (int i = 0; i < 5; i++) begin
      transacao($sformatf("hum_sub%0d", i), 1'b1, 3'd0, 4'(i), 4'd1, 2, 1'b0, cs, ca, rc, re);
      chk($sformatf("hum_sub%0d ack_cycle", i), ca, 4);
      chk($sformatf("hum_sub%0d erro", i), int'(re), 0);
    end
    transacao("hum_sub6", 1'b1, 3'd0, 4'd7, 4'd7, 2, 1'b0, cs, ca, rc, re);
    chk("hum_sub6 start_cycle", cs, -1);
    chk("hum_sub6 ack_cycle", ca, 1);
    chk("hum_sub6 erro", int'(re), 1);
    chk("hum submarino count", int'(dut.u_frota_hum.cnt[0]), 5);

    // Reset while the validator is busy.
    tipo_cpu = 3'd1; x_cpu = 4'd5; y_cpu = 4'd5; req_cpu = 1;
    step();
    chk("rst_wait val_start", int'(vif.val_start), 1);
    step();
    reset = 1'b0;
    step();
    chk("rst_wait outputs", int'({ack_cpu, gnt_cpu, gnt_hum, vif.val_start, resp_erro,
                                  fleet_done_cpu, start_game}), 0);
    chk("rst_wait cpu counts", int'(dut.u_frota_cpu.cnt), 0);
    chk("rst_wait hum counts", int'(dut.u_frota_hum.cnt), 0);
    reset = 1'b1; req_cpu = 0;
    begin
      int n_ack = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (ack_cpu || ack_hum) n_ack++;
      end
      chk("rst_wait no ack", n_ack, 0);
    end

    // Both requesters held high: CPU first, then strict alternation.
    do_reset();
    tipo_cpu = 3'd0; x_cpu = 4'd1; y_cpu = 4'd1;
    tipo_hum = 3'd0; x_hum = 4'd2; y_hum = 4'd2;
    req_cpu = 1; req_hum = 1;
    begin
      int s = -1;
      int both = 0;
      for (int cyc = 1; cyc < 80 && acks.size() < 4; cyc++) begin
        step();
        if (gnt_cpu && gnt_hum) both++;
        if (vif.val_start) begin
          s = cyc;
          gnts.push_back(int'(gnt_hum));
        end
        if (ack_cpu) acks.push_back(0);
        if (ack_hum) acks.push_back(1);
        if (acks.size() == 4) begin req_cpu = 0; req_hum = 0; end
        vif.val_done = (s > 0) && (cyc == s + 2);
        vif.val_conflito = 1'b0;
      end
      vif.val_done = 0;
      step();
      chk("rr ack count", acks.size(), 4);
      chk("rr both granted", both, 0);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rr ack%0d owner", i), (i < acks.size()) ? acks[i] : -1, i % 2);
        chk($sformatf("rr gnt%0d owner", i), (i < gnts.size()) ? gnts[i] : -1, i % 2);
      end
    end

    // Both fleets completed.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i == 10) chk("cpu fleet not yet done", int'(fleet_done_cpu), 0);
      transacao($sformatf("frota_cpu%0d", i), 1'b0, frota[i], 4'(i % 10), 4'd2, 2, 1'b0,
                cs, ca, rc, re);
      chk($sformatf("frota_cpu%0d ack_cycle", i), ca, 4);
    end
    chk("fleet_done_cpu", int'(fleet_done_cpu), 1);
    chk("start_game one fleet", int'(start_game), 0);
    for (int i = 0; i < 11; i++) begin
      transacao($sformatf("frota_hum%0d", i), 1'b1, frota[i], 4'd6, 4'(9 - (i % 10)), 2, 1'b0,
                cs, ca, rc, re);
      chk($sformatf("frota_hum%0d ack_cycle", i), ca, 4);
    end
    chk("fleet_done_hum", int'(fleet_done_hum), 1);
    chk("start_game", int'(start_game), 1);
    transacao("cpu after full", 1'b0, 3'd3, 4'd1, 4'd1, 2, 1'b0, cs, ca, rc, re);
    chk("cpu after full erro", int'(re), 1);
    reset = 1'b0;
    step();
    chk("start_game after reset", int'(start_game), 0);
    chk("fleet_done after reset", int'({fleet_done_cpu, fleet_done_hum}), 0);
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
